// File: rtl/rs_alloc_if.sv
// Dispatch-stage request interface of one reservation-station type.
// The dispatcher drives the requests; the allocator answers with grants and occupancy.
interface rs_alloc_if #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = $clog2(ENT_NUM)
);
    logic               req1_i;
    logic               req2_i;
    logic [1:0]         reqnum_i;
    logic               stall_dp_i;
    logic               kill_i;
    logic               free_en_i;
    logic [ENT_SEL-1:0] free_idx_i;
    logic [ENT_SEL-1:0] alloc1_idx_o;
    logic [ENT_SEL-1:0] alloc2_idx_o;
    logic               allocatable_o;
    logic               alloc_fire_o;
    logic [ENT_SEL:0]   free_cnt_o;
    logic [ENT_NUM-1:0] busy_vec_o;

    modport master (
        output req1_i, req2_i, reqnum_i, stall_dp_i, kill_i, free_en_i, free_idx_i,
        input  alloc1_idx_o, alloc2_idx_o, allocatable_o, alloc_fire_o, free_cnt_o, busy_vec_o
    );

    modport slave (
        input  req1_i, req2_i, reqnum_i, stall_dp_i, kill_i, free_en_i, free_idx_i,
        output alloc1_idx_o, alloc2_idx_o, allocatable_o, alloc_fire_o, free_cnt_o, busy_vec_o
    );
endinterface

// File: rtl/rs_alloc_unit.sv
// Reservation-station entry allocator: busy bitmap, two-wide lowest-free grant,
// release on issue, full release on kill.
module rs_alloc_unit #(
    parameter int ENT_NUM = 8,
    parameter int ENT_SEL = $clog2(ENT_NUM)
) (
    input  logic     clk_i,
    input  logic     reset_i,
    rs_alloc_if.slave rs
);
    logic [ENT_NUM-1:0] busy;
    logic [ENT_SEL:0]   free_cnt;
    logic [ENT_NUM-1:0] busy_nxt;
    logic [ENT_SEL:0]   free_cnt_nxt;
    logic [ENT_SEL:0]   busy_cnt;
    logic [ENT_SEL-1:0] f0;
    logic [ENT_SEL-1:0] f1;
    logic               found0;
    logic               found1;
    logic [ENT_SEL-1:0] a1;
    logic [ENT_SEL-1:0] a2;
    logic               allocatable;
    logic               fire;
    logic               free_ok;

    // Candidates come from registered busy only, so a same-cycle free is not reusable yet.
    always_comb begin
        f0     = '0;
        f1     = '0;
        found0 = 1'b0;
        found1 = 1'b0;
        for (int i = 0; i < ENT_NUM; i++) begin
            if (!busy[i]) begin
                if (!found0) begin
                    f0     = ENT_SEL'(i);
                    found0 = 1'b1;
                end else if (!found1) begin
                    f1     = ENT_SEL'(i);
                    found1 = 1'b1;
                end
            end
        end
    end

    always_comb begin
        a1          = f0;
        a2          = rs.req1_i ? f1 : f0;
        allocatable = (free_cnt >= (ENT_SEL+1)'(rs.reqnum_i));
        fire        = (rs.reqnum_i != 2'd0) && allocatable && !rs.stall_dp_i && !rs.kill_i;
        free_ok     = rs.free_en_i && !rs.kill_i && (int'(rs.free_idx_i) < ENT_NUM)
                      && busy[rs.free_idx_i];
    end

    // Count is recomputed from the next bitmap so it can never drift from busy,
    // even when an illegal reqnum/req combination makes two grants collide.
    always_comb begin
        busy_nxt = busy;
        if (fire && rs.req1_i) busy_nxt[a1] = 1'b1;
        if (fire && rs.req2_i) busy_nxt[a2] = 1'b1;
        if (free_ok)           busy_nxt[rs.free_idx_i] = 1'b0;
        if (rs.kill_i)         busy_nxt = '0;
        busy_cnt = '0;
        for (int i = 0; i < ENT_NUM; i++) begin
            busy_cnt = busy_cnt + (ENT_SEL+1)'(busy_nxt[i]);
        end
        free_cnt_nxt = (ENT_SEL+1)'(ENT_NUM) - busy_cnt;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy     <= '0;
            free_cnt <= (ENT_SEL+1)'(ENT_NUM);
        end else begin
            busy     <= busy_nxt;
            free_cnt <= free_cnt_nxt;
        end
    end

    assign rs.alloc1_idx_o  = a1;
    assign rs.alloc2_idx_o  = a2;
    assign rs.allocatable_o = allocatable;
    assign rs.alloc_fire_o  = fire;
    assign rs.free_cnt_o    = free_cnt;
    assign rs.busy_vec_o    = busy;
endmodule

// File: tb/tb_rs_alloc_unit.sv
// Self-checking bench for rs_alloc_unit: expected grants are queued when a request
// is driven and compared when the combinational outputs settle.
module tb_rs_alloc_unit;
    localparam int ENT_NUM = 8;
    localparam int ENT_SEL = 3;

    typedef struct packed {
        logic [2:0] i1;
        logic [2:0] i2;
        logic       alloc_ok;
        logic       fire;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    rs_alloc_if #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) rs ();

    rs_alloc_unit #(.ENT_NUM(ENT_NUM), .ENT_SEL(ENT_SEL)) dut (
        .clk_i   (clk),
        .reset_i (rst_n),
        .rs      (rs)
    );

    // Drive one cycle of stimulus, queue the expected grant, then score it before the edge.
    task automatic step(input string nm, input logic r1, input logic r2, input logic st,
                        input logic kl, input logic fe, input logic [2:0] fi,
                        input logic [2:0] e1, input logic [2:0] e2,
                        input logic ea, input logic ef);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rs.req1_i     = r1;
        rs.req2_i     = r2;
        rs.reqnum_i   = {1'b0, r1} + {1'b0, r2};
        rs.stall_dp_i = st;
        rs.kill_i     = kl;
        rs.free_en_i  = fe;
        rs.free_idx_i = fi;
        e.i1 = e1;
        e.i2 = e2;
        e.alloc_ok = ea;
        e.fire = ef;
        sb.push_back(e);
        #1;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", nm);
        end else begin
            got = sb.pop_front();
            checks++;
            if (rs.alloc1_idx_o !== got.i1) begin
                errors++;
                $display("FAIL %s alloc1: got %0d expected %0d", nm, rs.alloc1_idx_o, got.i1);
            end
            checks++;
            if (rs.alloc2_idx_o !== got.i2) begin
                errors++;
                $display("FAIL %s alloc2: got %0d expected %0d", nm, rs.alloc2_idx_o, got.i2);
            end
            checks++;
            if (rs.allocatable_o !== got.alloc_ok) begin
                errors++;
                $display("FAIL %s allocatable: got %b expected %b", nm, rs.allocatable_o, got.alloc_ok);
            end
            checks++;
            if (rs.alloc_fire_o !== got.fire) begin
                errors++;
                $display("FAIL %s fire: got %b expected %b", nm, rs.alloc_fire_o, got.fire);
            end
        end
    endtask

    task automatic idle_inputs();
        rs.req1_i     = 1'b0;
        rs.req2_i     = 1'b0;
        rs.reqnum_i   = 2'd0;
        rs.stall_dp_i = 1'b0;
        rs.kill_i     = 1'b0;
        rs.free_en_i  = 1'b0;
        rs.free_idx_i = 3'd0;
    endtask

    task automatic state_is(input string nm, input logic [7:0] eb, input logic [3:0] ec);
        @(posedge clk);
        #1;
        checks++;
        if (rs.busy_vec_o !== eb) begin
            errors++;
            $display("FAIL %s busy: got %h expected %h", nm, rs.busy_vec_o, eb);
        end
        checks++;
        if (rs.free_cnt_o !== ec) begin
            errors++;
            $display("FAIL %s free_cnt: got %0d expected %0d", nm, rs.free_cnt_o, ec);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        checks++;
        if (rs.busy_vec_o !== 8'h00 || rs.free_cnt_o !== 4'd8) begin
            errors++;
            $display("FAIL reset state: got busy %h cnt %0d expected 00 8", rs.busy_vec_o, rs.free_cnt_o);
        end
        checks++;
        if (rs.alloc1_idx_o !== 3'd0 || rs.alloc2_idx_o !== 3'd0 || rs.allocatable_o !== 1'b1
            || rs.alloc_fire_o !== 1'b0) begin
            errors++;
            $display("FAIL reset outputs: got %0d %0d %b %b expected 0 0 1 0", rs.alloc1_idx_o,
                     rs.alloc2_idx_o, rs.allocatable_o, rs.alloc_fire_o);
        end
        rs.req1_i = 1'b1;
        #1;
        checks++;
        if (rs.alloc2_idx_o !== 3'd1) begin
            errors++;
            $display("FAIL reset alloc2 with req1: got %0d expected 1", rs.alloc2_idx_o);
        end
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        step("fill0", 1, 1, 0, 0, 0, 0, 3'd0, 3'd1, 1, 1);
        step("fill1", 1, 1, 0, 0, 0, 0, 3'd2, 3'd3, 1, 1);
        step("fill2", 1, 1, 0, 0, 0, 0, 3'd4, 3'd5, 1, 1);
        step("fill3", 1, 1, 0, 0, 0, 0, 3'd6, 3'd7, 1, 1);
        state_is("full", 8'hFF, 4'd0);
        step("full_req", 1, 1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 0);
    endtask

    task automatic test_full_free();
        step("full_free", 1, 0, 0, 0, 1, 3'd3, 3'd0, 3'd0, 0, 0);
        state_is("after_free3", 8'hF7, 4'd1);
        step("realloc3", 1, 0, 0, 0, 0, 0, 3'd3, 3'd0, 1, 1);
        state_is("refull", 8'hFF, 4'd0);
    endtask

    task automatic test_no_partial();
        step("free5", 0, 0, 0, 0, 1, 3'd5, 3'd0, 3'd0, 1, 0);
        state_is("seven_busy", 8'hDF, 4'd1);
        step("partial", 1, 1, 0, 0, 0, 0, 3'd5, 3'd0, 0, 0);
        state_is("no_partial", 8'hDF, 4'd1);
        step("lone_req2", 0, 1, 0, 0, 0, 0, 3'd5, 3'd5, 1, 1);
        state_is("lone_req2_state", 8'hFF, 4'd0);
    endtask

    task automatic test_stall();
        step("kill_full", 0, 0, 0, 1, 0, 0, 3'd0, 3'd0, 1, 0);
        state_is("killed", 8'h00, 4'd8);
        step("one", 1, 0, 0, 0, 0, 0, 3'd0, 3'd1, 1, 1);
        step("two", 1, 1, 0, 0, 0, 0, 3'd1, 3'd2, 1, 1);
        step("free1", 0, 0, 0, 0, 1, 3'd1, 3'd3, 3'd3, 1, 0);
        state_is("pre_stall", 8'h05, 4'd6);
        step("stall0", 1, 1, 1, 0, 0, 0, 3'd1, 3'd3, 1, 0);
        step("stall1", 1, 1, 1, 0, 0, 0, 3'd1, 3'd3, 1, 0);
        state_is("stalled", 8'h05, 4'd6);
        step("release", 1, 1, 0, 0, 0, 0, 3'd1, 3'd3, 1, 1);
        state_is("post_stall", 8'h0F, 4'd4);
    endtask

    task automatic test_kill();
        step("kill_clear", 0, 0, 0, 1, 0, 0, 3'd4, 3'd4, 1, 0);
        state_is("kill_clear_state", 8'h00, 4'd8);
        for (int k = 0; k < 4; k++) begin
            step("refill", 1, 1, 0, 0, 0, 0, 3'(2 * k), 3'(2 * k + 1), 1, 1);
        end
        for (int k = 0; k < 4; k++) begin
            step("drain", 0, 0, 0, 0, 1, 3'(k), 3'd0, 3'd0, 1, 0);
        end
        state_is("busy_f0", 8'hF0, 4'd4);
        step("kill_all", 1, 1, 0, 1, 1, 3'd4, 3'd0, 3'd1, 1, 0);
        state_is("kill_state", 8'h00, 4'd8);
    endtask

    task automatic test_bogus_free();
        step("take0", 1, 0, 0, 0, 0, 0, 3'd0, 3'd1, 1, 1);
        step("bogus2", 0, 0, 0, 0, 1, 3'd2, 3'd1, 3'd1, 1, 0);
        state_is("bogus_state", 8'h01, 4'd7);
    endtask

    task automatic test_async_reset();
        step("pre_rst", 1, 1, 0, 0, 0, 0, 3'd1, 3'd2, 1, 1);
        state_is("pre_rst_state", 8'h07, 4'd5);
        @(negedge clk);
        idle_inputs();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rs.busy_vec_o !== 8'h00 || rs.free_cnt_o !== 4'd8 || rs.alloc1_idx_o !== 3'd0
            || rs.allocatable_o !== 1'b1) begin
            errors++;
            $display("FAIL async_reset: got busy %h cnt %0d a1 %0d ok %b expected 00 8 0 1",
                     rs.busy_vec_o, rs.free_cnt_o, rs.alloc1_idx_o, rs.allocatable_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1, 0, 0, 0, 0, 0, 3'd0, 3'd1, 1, 1);
        state_is("post_rst_state", 8'h01, 4'd7);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_full_free();
        test_no_partial();
        test_stall();
        test_kill();
        test_bogus_free();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard leftover: got %0d entries expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
